// File: rtl/rain_alarm_unit_pkg.sv
// Shared constants and state type for the rain-detection front end.
package rain_pkg;

    localparam int RAIN_DEBOUNCE_DEF = 2;
    localparam int RAIN_HOLD_DEF     = 0;
    localparam int RAIN_CNT_W        = 16;

    // Run counter covers DEBOUNCE_CYCLES up to 255; hold counter covers HOLD_CYCLES up to 65535.
    localparam int RAIN_DCNT_W = 8;
    localparam int RAIN_HCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAIN = 2'd1,
        HOLD = 2'd2
    } rain_state_t;

endpackage

// File: rtl/rain_alarm_unit_sync_debounce.sv
// Two-flop synchronizer followed by a run-length debounce filter.
// dout is the filtered level the filter is about to take on the next edge.
module sync_debounce
    import rain_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = RAIN_DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [RAIN_DCNT_W-1:0] DB_LAST = RAIN_DCNT_W'(DEBOUNCE_CYCLES);

    logic                   s1;
    logic                   s2;
    logic                   filt;
    logic                   filt_d;
    logic [RAIN_DCNT_W-1:0] dcnt;
    logic [RAIN_DCNT_W-1:0] dcnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        filt_d = filt;
        dcnt_d = '0;
        if (s2 != filt) begin
            if (dcnt + RAIN_DCNT_W'(1) == DB_LAST) begin
                filt_d = s2;
            end else begin
                dcnt_d = dcnt + RAIN_DCNT_W'(1);
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so s2 samples the old s1, not the new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            filt <= 1'b0;
            dcnt <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            filt <= filt_d;
            dcnt <= dcnt_d;
        end
    end

    // Exposing the next level lets the alarm register change on the same edge as filt.
    assign dout = filt_d;

endmodule

// File: rtl/rain_alarm_unit.sv
// Rain alarm: debounced sensor -> IDLE/RAIN/HOLD state machine, event pulse
// and saturating event counter. All outputs come straight from flops.
module rain_alarm_unit
    import rain_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = RAIN_DEBOUNCE_DEF,
    parameter int HOLD_CYCLES     = RAIN_HOLD_DEF,
    parameter int CNT_W           = RAIN_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rain_sensor,
    output logic             rain_alarm,
    output logic             rain_event,
    output logic [CNT_W-1:0] rain_count
);

    localparam logic [RAIN_HCNT_W-1:0] HOLD_LD = RAIN_HCNT_W'(HOLD_CYCLES);

    rain_state_t            state_q;
    rain_state_t            state_d;
    logic [RAIN_HCNT_W-1:0] hcnt_q;
    logic [RAIN_HCNT_W-1:0] hcnt_d;
    logic                   filt_nx;
    logic                   alarm_d;
    logic                   event_d;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (rain_sensor),
        .dout (filt_nx)
    );

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        event_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (filt_nx) begin
                    state_d = RAIN;
                    event_d = 1'b1;
                end
            end
            RAIN: begin
                if (!filt_nx) begin
                    if (HOLD_LD == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                        hcnt_d  = HOLD_LD;
                    end
                end
            end
            HOLD: begin
                // Rain returning inside the hold window resumes the same episode.
                if (filt_nx) begin
                    state_d = RAIN;
                end else if (hcnt_q == RAIN_HCNT_W'(1)) begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d = hcnt_q - RAIN_HCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        alarm_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hcnt_q     <= '0;
            rain_alarm <= 1'b0;
            rain_event <= 1'b0;
            rain_count <= '0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            rain_alarm <= alarm_d;
            rain_event <= event_d;
            if (event_d && (rain_count != {CNT_W{1'b1}})) begin
                rain_count <= rain_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rain_alarm_unit.sv
// Directed bench for rain_alarm_unit: four parameterisations share clk and rst,
// each driven by its own sensor line from one linear stimulus sequence.
module tb_rain_alarm_unit;
    import rain_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sens0, sens1, sens2, sens3;
    logic        alarm0, alarm1, alarm2, alarm3;
    logic        event0, event1, event2, event3;
    logic [15:0] cnt0, cnt1, cnt2;
    logic [1:0]  cnt3;

    int total = 0;
    int bad   = 0;
    int ev0   = 0;
    int ev2   = 0;

    rain_alarm_unit u0 (
        .clk(clk), .rst(rst), .rain_sensor(sens0),
        .rain_alarm(alarm0), .rain_event(event0), .rain_count(cnt0)
    );

    rain_alarm_unit #(.DEBOUNCE_CYCLES(4)) u1 (
        .clk(clk), .rst(rst), .rain_sensor(sens1),
        .rain_alarm(alarm1), .rain_event(event1), .rain_count(cnt1)
    );

    rain_alarm_unit #(.HOLD_CYCLES(10)) u2 (
        .clk(clk), .rst(rst), .rain_sensor(sens2),
        .rain_alarm(alarm2), .rain_event(event2), .rain_count(cnt2)
    );

    rain_alarm_unit #(.CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .rain_sensor(sens3),
        .rain_alarm(alarm3), .rain_event(event3), .rain_count(cnt3)
    );

    always @(negedge clk) begin
        if (event0 === 1'b1) ev0 = ev0 + 1;
        if (event2 === 1'b1) ev2 = ev2 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic toggle_lv [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic toggle_al [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int   sat_exp   [5] = '{1, 2, 3, 3, 3};
    int   base;

    initial begin
        rst   = 1'b1;
        sens0 = 1'b1;
        sens1 = 1'b0;
        sens2 = 1'b0;
        sens3 = 1'b0;

        // Reset held 3 cycles with the sensor high.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_alarm", 32'(alarm0), 32'd0);
            check("rst_event", 32'(event0), 32'd0);
            check("rst_count", 32'(cnt0), 32'd0);
        end
        check("rst_alarm_u1", 32'(alarm1), 32'd0);
        check("rst_alarm_u2", 32'(alarm2), 32'd0);
        check("rst_count_u3", 32'(cnt3), 32'd0);
        rst   = 1'b0;
        sens0 = 1'b0;

        // Default toggle: alarm sampled at each level change.
        base = ev0;
        for (int i = 0; i < 5; i++) begin
            check("toggle_alarm", 32'(alarm0), 32'(toggle_al[i]));
            sens0 = toggle_lv[i];
            tick(5);
        end
        check("toggle_events", 32'(ev0 - base), 32'd1);
        check("toggle_count", 32'(cnt0), 32'd1);

        // Glitch rejection with DEBOUNCE_CYCLES=4: 3-cycle pulse ignored.
        sens1 = 1'b1;
        tick(3);
        sens1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("glitch_alarm", 32'(alarm1), 32'd0);
        end
        check("glitch_count", 32'(cnt1), 32'd0);

        // 4-cycle pulse accepted; alarm rises exactly 6 cycles after sensor rise.
        sens1 = 1'b1;
        tick(4);
        sens1 = 1'b0;
        tick(1);
        check("pulse4_alarm_early", 32'(alarm1), 32'd0);
        tick(1);
        check("pulse4_alarm", 32'(alarm1), 32'd1);
        check("pulse4_event", 32'(event1), 32'd1);
        check("pulse4_count", 32'(cnt1), 32'd1);
        tick(1);
        check("pulse4_event_once", 32'(event1), 32'd0);
        tick(2);
        check("pulse4_fall_late", 32'(alarm1), 32'd1);
        tick(1);
        check("pulse4_fall", 32'(alarm1), 32'd0);

        // Hold with HOLD_CYCLES=10: sensor drops, returns after 6 cycles.
        sens2 = 1'b1;
        tick(4);
        check("hold_rise_alarm", 32'(alarm2), 32'd1);
        check("hold_rise_event", 32'(event2), 32'd1);
        tick(4);
        base  = ev2;
        sens2 = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            tick(1);
            if (j == 6) sens2 = 1'b1;
            check("hold_alarm_cont", 32'(alarm2), 32'd1);
        end
        check("hold_no_event", 32'(ev2 - base), 32'd0);
        check("hold_count", 32'(cnt2), 32'd1);

        // Hold expiry: alarm drops exactly 2+2+10 cycles after sensor fall.
        sens2 = 1'b0;
        tick(13);
        check("hold_expire_late", 32'(alarm2), 32'd1);
        tick(1);
        check("hold_expire", 32'(alarm2), 32'd0);
        check("hold_state_idle", 32'(u2.state_q), 32'(IDLE));

        // Saturation with CNT_W=2 over five episodes.
        for (int e = 0; e < 5; e++) begin
            sens3 = 1'b1;
            tick(6);
            sens3 = 1'b0;
            tick(6);
            check("sat_count", 32'(cnt3), 32'(sat_exp[e]));
        end
        check("sat_alarm_low", 32'(alarm3), 32'd0);

        // Mid-hold reset on u2.
        sens2 = 1'b1;
        tick(6);
        check("midrst_pre_count", 32'(cnt2), 32'd2);
        sens2 = 1'b0;
        tick(6);
        check("midrst_pre_alarm", 32'(alarm2), 32'd1);
        check("midrst_pre_state", 32'(u2.state_q), 32'(HOLD));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_alarm", 32'(alarm2), 32'd0);
        check("midrst_event", 32'(event2), 32'd0);
        check("midrst_count", 32'(cnt2), 32'd0);
        check("midrst_state", 32'(u2.state_q), 32'(IDLE));
        check("midrst_count_u0", 32'(cnt0), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("midrst_stay_low", 32'(alarm2), 32'd0);
        end

        // Reset mid-debounce discards the partial run; a fresh full interval is needed.
        sens2 = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(3);
        check("dbrst_alarm_early", 32'(alarm2), 32'd0);
        tick(1);
        check("dbrst_alarm", 32'(alarm2), 32'd1);
        check("dbrst_event", 32'(event2), 32'd1);
        check("dbrst_count", 32'(cnt2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
